control_sequencer: RTL and testbench



---
 rtl/control_sequencer_pkg.sv | 69 ++++++
 rtl/control_sequencer_instr_decode.sv | 39 +++
 rtl/control_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// state encoding, instruction classes and the ALU one-hot bit layout.
package cpu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 10;

    // Opcode values (IR[31:27])
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU one-hot, MSB first in the same order as the top-level ports
    typedef logic [ALU_W-1:0] alu_oh_t;
    localparam alu_oh_t ALU_NONE = 10'b00_0000_0000;
    localparam alu_oh_t ALU_ADD  = 10'b10_0000_0000;
    localparam alu_oh_t ALU_SUB  = 10'b01_0000_0000;
    localparam alu_oh_t ALU_AND  = 10'b00_1000_0000;
    localparam alu_oh_t ALU_OR   = 10'b00_0100_0000;
    localparam alu_oh_t ALU_SHR  = 10'b00_0010_0000;
    localparam alu_oh_t ALU_SHL  = 10'b00_0001_0000;
    localparam alu_oh_t ALU_ROR  = 10'b00_0000_1000;
    localparam alu_oh_t ALU_ROL  = 10'b00_0000_0100;
    localparam alu_oh_t ALU_NEG  = 10'b00_0000_0010;
    localparam alu_oh_t ALU_NOT  = 10'b00_0000_0001;

    // Sequencer states; every state lasts exactly one cycle
    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    // Instruction classes: members of a class share one execute sequence
    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_UNARY,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_BAD
    } cls_t;

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational opcode decoder: opcode -> instruction class plus the ALU
// one-hot used during the ALU step of that instruction. Address-forming
// classes (ld/ldi/st) report ADD because their effective address is C+Rb.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output cls_t            o_cls,
    output alu_oh_t         o_alu
);

    // Opcode table lookup
    always_comb begin
        o_cls = CLS_BAD;
        o_alu = ALU_NONE;
        case (i_op)
            OP_LD:   begin o_cls = CLS_LD;    o_alu = ALU_ADD; end
            OP_LDI:  begin o_cls = CLS_LDI;   o_alu = ALU_ADD; end
            OP_ST:   begin o_cls = CLS_ST;    o_alu = ALU_ADD; end
            OP_ADD:  begin o_cls = CLS_ALU_R; o_alu = ALU_ADD; end
            OP_SUB:  begin o_cls = CLS_ALU_R; o_alu = ALU_SUB; end
            OP_AND:  begin o_cls = CLS_ALU_R; o_alu = ALU_AND; end
            OP_OR:   begin o_cls = CLS_ALU_R; o_alu = ALU_OR;  end
            OP_SHR:  begin o_cls = CLS_ALU_R; o_alu = ALU_SHR; end
            OP_SHL:  begin o_cls = CLS_ALU_R; o_alu = ALU_SHL; end
            OP_ROR:  begin o_cls = CLS_ALU_R; o_alu = ALU_ROR; end
            OP_ROL:  begin o_cls = CLS_ALU_R; o_alu = ALU_ROL; end
            OP_ADDI: begin o_cls = CLS_ALU_I; o_alu = ALU_ADD; end
            OP_ANDI: begin o_cls = CLS_ALU_I; o_alu = ALU_AND; end
            OP_ORI:  begin o_cls = CLS_ALU_I; o_alu = ALU_OR;  end
            OP_NEG:  begin o_cls = CLS_UNARY; o_alu = ALU_NEG; end
            OP_NOT:  begin o_cls = CLS_UNARY; o_alu = ALU_NOT; end
            OP_NOP:  o_cls = CLS_NOP;
            OP_HALT: o_cls = CLS_HALT;
            default: o_cls = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Datapath. Moore state machine stepping
// fetch (T0-T2) and per-class execute steps (T3-T7); every control output
// is decoded from the state register and the IR opcode.
// Optional feature macro: ILLEGAL_TRAP_EN -- undefined opcodes trap to HALT
// and raise a sticky illegal flag. Without it they execute as nop.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic [IRW-1:0] IR,
    input  logic           stop,
    output logic           clear,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           Cout,
    output logic           BAout,
    output logic           Rout,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           ADD,
    output logic           SUB,
    output logic           AND,
    output logic           OR,
    output logic           SHR,
    output logic           SHL,
    output logic           ROR,
    output logic           ROL,
    output logic           NEG,
    output logic           NOT,
    output logic           run,
    output logic           illegal
);

    state_t   r_state;
    state_t   w_step;
    state_t   w_next;
    cls_t     w_cls;
    alu_oh_t  w_alu;
    alu_oh_t  w_alu_out;
    logic     w_trap;

    // Only the opcode field matters to control; operand fields go to the Datapath
    logic w_unused_ir;
    assign w_unused_ir = ^IR[IRW-OPW-1:0];

    instr_decode u_decode (
        .i_op  (IR[IRW-1 -: OPW]),
        .o_cls (w_cls),
        .o_alu (w_alu)
    );

`ifdef ILLEGAL_TRAP_EN
    assign w_trap = (r_state == T2) && (w_cls == CLS_BAD);
`else
    assign w_trap = 1'b0;
`endif

    // Next-state: natural successor, then the stop request diverts any entry into T0
    always_comb begin
        w_step = r_state;
        case (r_state)
            RST: w_step = T0;
            T0:  w_step = T1;
            T1:  w_step = T2;
            T2: begin
                case (w_cls)
                    CLS_NOP:  w_step = T0;
                    CLS_HALT: w_step = HALT;
                    CLS_BAD:  w_step = w_trap ? HALT : T0;
                    default:  w_step = T3;
                endcase
            end
            T3:  w_step = T4;
            T4:  w_step = (w_cls == CLS_UNARY) ? T0 : T5;
            T5:  w_step = (w_cls == CLS_LD || w_cls == CLS_ST) ? T6 : T0;
            T6:  w_step = T7;
            T7:  w_step = T0;
            HALT: w_step = HALT;
            default: w_step = RST;
        endcase
        w_next = (w_step == T0 && stop) ? HALT : w_step;
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) r_state <= RST;
        else          r_state <= w_next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky undefined-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)    r_illegal <= 1'b0;
        else if (w_trap) r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = w_alu_out;

    // Control decode: one step of microcode per state, keyed by class in execute
    always_comb begin
        clear     = 1'b0;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        Cout      = 1'b0;
        BAout     = 1'b0;
        Rout      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        w_alu_out = ALU_NONE;
        run       = (r_state != HALT);
        case (r_state)
            RST: clear = 1'b1;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_out = w_alu;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (w_cls)
                    CLS_ALU_R: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_out = w_alu;
                    end
                    CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST: begin
                        Cout = 1'b1; Zin = 1'b1; w_alu_out = w_alu;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (w_cls)
                    CLS_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    CLS_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (w_cls)
                    CLS_LD: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    CLS_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instruction sequences one cycle
// at a time and compares the full control vector against hand-built masks.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [31:0] IR;
    logic        stop;
    logic clear, PCout, Zlowout, MDRout, Cout, BAout, Rout, Gra, Grb, Grc, Rin;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, run, illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OPW(5), .IRW(32)) dut (
        .clk(clk), .clear_n(clear_n), .IR(IR), .stop(stop),
        .clear(clear), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .run(run),
        .illegal(illegal)
    );

    logic [31:0] ctl;
    assign ctl = {illegal, clear, PCout, Zlowout, MDRout, Cout, BAout, Rout,
                  Gra, Grb, Grc, Rin, MARin, Zin, PCin, MDRin, IRin, Yin,
                  IncPC, Read, Write, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL,
                  NEG, NOT, run};

    localparam logic [31:0] E_ILL  = 32'h1 << 31;
    localparam logic [31:0] E_CLR  = 32'h1 << 30;
    localparam logic [31:0] E_PCO  = 32'h1 << 29;
    localparam logic [31:0] E_ZLO  = 32'h1 << 28;
    localparam logic [31:0] E_MDRO = 32'h1 << 27;
    localparam logic [31:0] E_CO   = 32'h1 << 26;
    localparam logic [31:0] E_BAO  = 32'h1 << 25;
    localparam logic [31:0] E_RO   = 32'h1 << 24;
    localparam logic [31:0] E_GRA  = 32'h1 << 23;
    localparam logic [31:0] E_GRB  = 32'h1 << 22;
    localparam logic [31:0] E_GRC  = 32'h1 << 21;
    localparam logic [31:0] E_RIN  = 32'h1 << 20;
    localparam logic [31:0] E_MARI = 32'h1 << 19;
    localparam logic [31:0] E_ZIN  = 32'h1 << 18;
    localparam logic [31:0] E_PCI  = 32'h1 << 17;
    localparam logic [31:0] E_MDRI = 32'h1 << 16;
    localparam logic [31:0] E_IRI  = 32'h1 << 15;
    localparam logic [31:0] E_YIN  = 32'h1 << 14;
    localparam logic [31:0] E_INC  = 32'h1 << 13;
    localparam logic [31:0] E_RD   = 32'h1 << 12;
    localparam logic [31:0] E_WR   = 32'h1 << 11;
    localparam logic [31:0] E_ADD  = 32'h1 << 10;
    localparam logic [31:0] E_SUB  = 32'h1 << 9;
    localparam logic [31:0] E_OR   = 32'h1 << 7;
    localparam logic [31:0] E_SHR  = 32'h1 << 6;
    localparam logic [31:0] E_NEG  = 32'h1 << 2;
    localparam logic [31:0] E_RUN  = 32'h1;

    localparam logic [31:0] X_RST = E_CLR | E_RUN;
    localparam logic [31:0] X_T0  = E_PCO | E_MARI | E_INC | E_ZIN | E_RUN;
    localparam logic [31:0] X_T1  = E_ZLO | E_PCI | E_RD | E_MDRI | E_RUN;
    localparam logic [31:0] X_T2  = E_MDRO | E_IRI | E_RUN;
    localparam logic [31:0] X_WB  = E_ZLO | E_GRA | E_RIN | E_RUN;
    localparam logic [31:0] X_EA3 = E_GRB | E_BAO | E_YIN | E_RUN;
    localparam logic [31:0] X_EA4 = E_CO | E_ADD | E_ZIN | E_RUN;
    localparam logic [31:0] X_R3  = E_GRB | E_RO | E_YIN | E_RUN;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (ctl === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, ctl, exp);
        end
    endtask

    // Checks the current T0 and steps through T1, T2
    task automatic fetch(input string tag);
        chk({tag, "_T0"}, X_T0);
        tick(); chk({tag, "_T1"}, X_T1);
        tick(); chk({tag, "_T2"}, X_T2);
    endtask

    initial begin
        clear_n = 1'b0;
        IR      = 32'h1080005A;   // st $5A,R1
        stop    = 1'b0;
        #12;
        chk("reset", X_RST);
        @(negedge clk); clear_n = 1'b1;
        #1 chk("rst_hold", X_RST);
        tick();

        // st
        fetch("st");
        tick(); chk("st_T3", X_EA3);
        tick(); chk("st_T4", X_EA4);
        tick(); chk("st_T5", E_ZLO | E_MARI | E_RUN);
        tick(); chk("st_T6", E_GRA | E_RO | E_MDRI | E_RUN);
        tick(); chk("st_T7", E_WR | E_RUN);
        tick();

        // add R3,R1,R2
        IR = 32'h19890000;
        fetch("add");
        tick(); chk("add_T3", X_R3);
        tick(); chk("add_T4", E_GRC | E_RO | E_ADD | E_ZIN | E_RUN);
        tick(); chk("add_T5", X_WB);
        tick();

        // ld R2,$40(R1)
        IR = 32'h01080040;
        fetch("ld");
        tick(); chk("ld_T3", X_EA3);
        tick(); chk("ld_T4", X_EA4);
        tick(); chk("ld_T5", E_ZLO | E_MARI | E_RUN);
        tick(); chk("ld_T6", E_RD | E_MDRI | E_RUN);
        tick(); chk("ld_T7", E_MDRO | E_GRA | E_RIN | E_RUN);
        tick();

        // ldi
        IR = 32'h08800010;
        fetch("ldi");
        tick(); chk("ldi_T3", X_EA3);
        tick(); chk("ldi_T4", X_EA4);
        tick(); chk("ldi_T5", X_WB);
        tick();

        // ori
        IR = 32'h69880007;
        fetch("ori");
        tick(); chk("ori_T3", X_R3);
        tick(); chk("ori_T4", E_CO | E_OR | E_ZIN | E_RUN);
        tick(); chk("ori_T5", X_WB);
        tick();

        // shr
        IR = 32'h39890000;
        fetch("shr");
        tick(); chk("shr_T3", X_R3);
        tick(); chk("shr_T4", E_GRC | E_RO | E_SHR | E_ZIN | E_RUN);
        tick(); chk("shr_T5", X_WB);
        tick();

        // neg
        IR = 32'h81100000;
        fetch("neg");
        tick(); chk("neg_T3", E_GRB | E_RO | E_NEG | E_ZIN | E_RUN);
        tick(); chk("neg_T4", X_WB);
        tick();

        // nop goes straight back to fetch
        IR = 32'hD0000000;
        fetch("nop");
        tick();

        // undefined opcode
        IR = 32'hF8000000;
        fetch("bad");
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("bad_trap", E_ILL);
        tick(); chk("bad_sticky", E_ILL);
        #2 clear_n = 1'b0;
        #1 chk("bad_reset", X_RST);
        @(negedge clk); clear_n = 1'b1;
        tick();
`endif
        chk("bad_next", X_T0);

        // stop raised during sub's T4: finish, then HALT without T0
        IR = 32'h21890000;
        fetch("sub");
        tick(); chk("sub_T3", X_R3);
        tick(); chk("sub_T4", E_GRC | E_RO | E_SUB | E_ZIN | E_RUN);
        stop = 1'b1;
        tick(); chk("stop_T5", X_WB);
        tick(); chk("stop_halt", 32'h0);
        tick(); chk("stop_hold", 32'h0);
        #2 clear_n = 1'b0;
        stop = 1'b0;
        #1 chk("stop_reset", X_RST);
        @(negedge clk); clear_n = 1'b1;
        tick();

        // halt: stays idle until reset
        IR = 32'hD8000000;
        fetch("halt");
        for (int i = 0; i < 22; i++) begin
            tick(); chk("halt_hold", 32'h0);
        end
        #2 clear_n = 1'b0;
        #1 chk("halt_reset", X_RST);
        @(negedge clk); clear_n = 1'b1;
        tick(); chk("post_reset_T0", X_T0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
